mac_array_feeder: RTL and testbench



---
 rtl/mac_array_pkg.sv | 17 +
 rtl/mac_skew_line.sv | 26 ++
 rtl/mac_array_feeder.sv | 97 +++++++++
 tb/tb_mac_array_feeder.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/mac_array_pkg.sv
// mac_array_pkg: shared types and helpers for the mac_array operand feeder
package mac_array_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        STREAM,
        FLUSH,
        WAIT,
        DONE
    } feeder_state_t;

    function automatic int FLUSH_LEN(input int m, input int n);
        return m + n - 1;
    endfunction

endpackage

// File: rtl/mac_skew_line.sv
// mac_skew_line: enable-gated shift register with synchronous clear, output is the deepest stage
module mac_skew_line #(
    parameter int DEPTH      = 1,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  clr,
    input  logic                  en,
    input  logic [DATA_WIDTH-1:0] d,
    output logic [DATA_WIDTH-1:0] q
);

    logic [DEPTH-1:0][DATA_WIDTH-1:0] sr;

    always_ff @(posedge clk) begin
        if (clr) begin
            sr <= '0;
        end else if (en) begin
            for (int k = DEPTH - 1; k > 0; k--) sr[k] <= sr[k-1];
            sr[0] <= d;
        end
    end

    assign q = sr[DEPTH-1];

endmodule

// File: rtl/mac_array_feeder.sv
// mac_array_feeder: sequences clear/stream/flush/done and feeds diagonally skewed operands into mac_array
module mac_array_feeder
    import mac_array_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int M_ROWS     = 4,
    parameter int N_COLS     = 4,
    parameter int K_W        = 8
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    input  logic                               start_i,
    input  logic [K_W-1:0]                     k_len_i,
    input  logic [M_ROWS-1:0][DATA_WIDTH-1:0]  a_slice_i,
    input  logic [N_COLS-1:0][DATA_WIDTH-1:0]  b_slice_i,
    input  logic                               slice_valid_i,
    output logic                               slice_ready_o,
    output logic [M_ROWS-1:0][DATA_WIDTH-1:0]  array_a_o,
    output logic [N_COLS-1:0][DATA_WIDTH-1:0]  array_b_o,
    output logic                               feed_a_valid_o,
    output logic                               feed_b_valid_o,
    output logic                               a_clr_o,
    output logic                               b_clr_o,
    output logic                               acc_clr_o,
    output logic                               busy_o,
    output logic                               done_o
);

    localparam int FL = FLUSH_LEN(M_ROWS, N_COLS);
    localparam int FW = $clog2(M_ROWS + N_COLS);

    feeder_state_t  state, state_nx;
    logic [K_W-1:0] k_len, cnt;
    logic [FW-1:0]  fcnt;
    logic           accept, adv, clr, last_slice, last_flush, feed_q;

    assign accept     = state == STREAM && slice_valid_i;
    assign adv        = accept || state == FLUSH;
    assign clr        = rst_i || state == CLEAR;
    assign last_slice = cnt + K_W'(1) == k_len;
    assign last_flush = fcnt == FW'(FL - 1);

    always_comb begin
        state_nx = state == IDLE   ? (start_i && k_len_i != '0 ? CLEAR : IDLE) :
                   state == CLEAR  ? STREAM :
                   state == STREAM ? (accept && last_slice ? FLUSH : STREAM) :
                   state == FLUSH  ? (last_flush ? WAIT : FLUSH) :
                   state == WAIT   ? DONE : IDLE;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state  <= IDLE;
            k_len  <= '0;
            cnt    <= '0;
            fcnt   <= '0;
            feed_q <= 1'b0;
        end else begin
            state  <= state_nx;
            feed_q <= adv;
            if (state == IDLE && start_i) k_len <= k_len_i;
            cnt    <= state == STREAM ? cnt + K_W'(accept) : '0;
            fcnt   <= state == FLUSH ? fcnt + FW'(1) : '0;
        end
    end

    // Lane i has i+1 stages so element i of a slice reaches the array i advances after element 0
    for (genvar i = 0; i < M_ROWS; i++) begin : g_a
        mac_skew_line #(.DEPTH(i + 1), .DATA_WIDTH(DATA_WIDTH)) u_line (
            .clk (clk_i),
            .clr (clr),
            .en  (adv),
            .d   (state == FLUSH ? '0 : a_slice_i[i]),
            .q   (array_a_o[i])
        );
    end

    for (genvar j = 0; j < N_COLS; j++) begin : g_b
        mac_skew_line #(.DEPTH(j + 1), .DATA_WIDTH(DATA_WIDTH)) u_line (
            .clk (clk_i),
            .clr (clr),
            .en  (adv),
            .d   (state == FLUSH ? '0 : b_slice_i[j]),
            .q   (array_b_o[j])
        );
    end

    assign slice_ready_o  = state == STREAM;
    assign feed_a_valid_o = feed_q;
    assign feed_b_valid_o = feed_q;
    assign a_clr_o        = state == CLEAR;
    assign b_clr_o        = state == CLEAR;
    assign acc_clr_o      = state == CLEAR;
    assign busy_o         = state != IDLE;
    assign done_o         = state == DONE;

endmodule

// File: tb/tb_mac_array_feeder.sv
// tb_mac_array_feeder: table-driven jobs plus corner sequences checked against a schedule-level model
module tb_mac_array_feeder;

    localparam int M  = 4;
    localparam int N  = 4;
    localparam int DW = 16;
    localparam int KW = 8;
    localparam int FL = M + N - 1;

    localparam int P_IDLE = 0, P_CLR = 1, P_STR = 2, P_FL = 3, P_WAIT = 4, P_DONE = 5;

    typedef logic [M-1:0][DW-1:0] avec_t;
    typedef logic [N-1:0][DW-1:0] bvec_t;
    typedef struct {
        avec_t a;
        bvec_t b;
    } pair_t;
    typedef struct {
        int k;
        int bp;
        int bl;
        bit poke;
        int exp_done;
    } job_t;

    logic          clk = 1'b0;
    logic          rst_i, start_i, slice_valid_i;
    logic [KW-1:0] k_len_i;
    avec_t         a_slice_i, array_a_o;
    bvec_t         b_slice_i, array_b_o;
    logic          slice_ready_o, feed_a_valid_o, feed_b_valid_o;
    logic          a_clr_o, b_clr_o, acc_clr_o, busy_o, done_o;

    mac_array_feeder #(.DATA_WIDTH(DW), .M_ROWS(M), .N_COLS(N), .K_W(KW)) dut (
        .clk_i          (clk),
        .rst_i          (rst_i),
        .start_i        (start_i),
        .k_len_i        (k_len_i),
        .a_slice_i      (a_slice_i),
        .b_slice_i      (b_slice_i),
        .slice_valid_i  (slice_valid_i),
        .slice_ready_o  (slice_ready_o),
        .array_a_o      (array_a_o),
        .array_b_o      (array_b_o),
        .feed_a_valid_o (feed_a_valid_o),
        .feed_b_valid_o (feed_b_valid_o),
        .a_clr_o        (a_clr_o),
        .b_clr_o        (b_clr_o),
        .acc_clr_o      (acc_clr_o),
        .busy_o         (busy_o),
        .done_o         (done_o)
    );

    always #5 clk = ~clk;

    int    n_tests = 0, n_fail = 0;
    bit    pat = 0;
    bit    m_busy = 0, m_feed = 0;
    int    m_t, m_k, m_acc, m_end;
    pair_t hist[$];
    job_t  jobs[6];

    task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, got, exp);
        end
    endtask

    // Job phase derived purely from elapsed cycles and accepted-slice count
    function automatic int phase();
        int f;
        if (!m_busy) return P_IDLE;
        if (m_t == 1) return P_CLR;
        if (m_acc < m_k) return P_STR;
        f = m_t - m_end;
        return f <= FL ? P_FL : f == FL + 1 ? P_WAIT : P_DONE;
    endfunction

    task automatic update(input bit r, input bit st, input int kl, input bit sv, input avec_t a, input bvec_t b);
        int    ph;
        bit    adv;
        pair_t p;
        ph  = phase();
        adv = (ph == P_STR && sv) || ph == P_FL;
        if (r) begin
            m_busy = 0;
            m_feed = 0;
            hist.delete();
            return;
        end
        m_feed = adv;
        if (ph == P_CLR) hist.delete();
        if (adv) begin
            p.a = ph == P_FL ? '0 : a;
            p.b = ph == P_FL ? '0 : b;
            hist.push_back(p);
        end
        if (ph == P_STR && sv) begin
            m_acc++;
            if (m_acc == m_k) m_end = m_t;
        end
        if (ph == P_DONE) m_busy = 0;
        else if (m_busy) m_t++;
        else if (st && kl != 0) begin
            m_busy = 1;
            m_t    = 1;
            m_k    = kl;
            m_acc  = 0;
        end
    endtask

    // Lane i presents the value pushed i advances before the newest one
    function automatic logic [127:0] exp_data();
        avec_t ea;
        bvec_t eb;
        int    idx;
        for (int i = 0; i < M; i++) begin
            idx   = hist.size() - 1 - i;
            ea[i] = idx >= 0 ? hist[idx].a[i] : '0;
        end
        for (int j = 0; j < N; j++) begin
            idx   = hist.size() - 1 - j;
            eb[j] = idx >= 0 ? hist[idx].b[j] : '0;
        end
        return {ea, eb};
    endfunction

    function automatic logic [7:0] exp_ctrl();
        int ph;
        ph = phase();
        return {ph == P_STR, m_feed, m_feed, ph == P_CLR, ph == P_CLR, ph == P_CLR, m_busy, ph == P_DONE};
    endfunction

    task automatic tick(input bit r, input bit st, input int kl, input bit sv);
        rst_i         = r;
        start_i       = st;
        k_len_i       = KW'(kl);
        slice_valid_i = sv;
        for (int i = 0; i < M; i++) a_slice_i[i] = pat ? DW'(10 * m_acc + i) : DW'($urandom);
        for (int j = 0; j < N; j++) b_slice_i[j] = DW'($urandom);
        @(posedge clk);
        update(r, st, kl, sv, a_slice_i, b_slice_i);
        #1;
        chk("ctrl", {slice_ready_o, feed_a_valid_o, feed_b_valid_o, a_clr_o, b_clr_o, acc_clr_o, busy_o, done_o}, exp_ctrl());
        chk("data", {array_a_o, array_b_o}, exp_data());
    endtask

    task automatic run_job(input int k, input int bp, input int bl, input bit poke, input int exp_done, input bit chk6);
        int cyc, bub, ph;
        bit seen, sv;
        tick(0, 1, k, 0);
        cyc  = 1;
        bub  = 0;
        seen = 0;
        while (!seen && cyc < 200) begin
            ph = phase();
            sv = !(ph == P_STR && m_acc == bp && bub < bl);
            if (!sv) bub++;
            tick(0, poke && ph == P_FL, 5, sv);
            cyc++;
            if (chk6 && cyc == 6) chk("a2_at_cycle6", 128'(array_a_o[2]), 128'(12));
            if (done_o) seen = 1;
        end
        chk("done_cycle", seen ? cyc : -1, exp_done);
        tick(0, 0, 0, 0);
    endtask

    initial begin
        jobs[0] = '{k: 4, bp: 0,  bl: 0, poke: 0, exp_done: 14};
        jobs[1] = '{k: 4, bp: 2,  bl: 2, poke: 1, exp_done: 16};
        jobs[2] = '{k: 1, bp: 0,  bl: 0, poke: 0, exp_done: 11};
        jobs[3] = '{k: 7, bp: 3,  bl: 1, poke: 1, exp_done: 18};
        jobs[4] = '{k: 2, bp: 1,  bl: 3, poke: 0, exp_done: 15};
        jobs[5] = '{k: 9, bp: 0,  bl: 2, poke: 0, exp_done: 21};

        for (int c = 0; c < 3; c++) tick(1, 1, 4, 1);
        tick(0, 0, 0, 0);

        for (int c = 0; c < 3; c++) tick(0, 1, 0, 1);

        pat = 1;
        run_job(4, 99, 0, 0, 14, 1);
        pat = 0;

        for (int n = 0; n < 6; n++)
            run_job(jobs[n].k, jobs[n].bp, jobs[n].bl, jobs[n].poke, jobs[n].exp_done, 0);

        tick(0, 1, 6, 0);
        for (int c = 0; c < 20 && m_acc < 2; c++) tick(0, 0, 0, 1);
        tick(1, 0, 0, 0);
        tick(0, 0, 0, 1);
        tick(0, 0, 0, 0);
        run_job(3, 1, 1, 0, 14, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
